// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the pipeline sequencing logic.
//   pipe_state_t : pipeline controller FSM states.
//   latch_ctrl_t : per-latch {en, flush} control pair.
//   LC_*         : common latch control encodings.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN,
    DSTALL,
    DRAIN,
    HALTED
  } pipe_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctrl_t;

  // A flushing latch also has en=1 so flush never pairs with a held latch.
  localparam latch_ctrl_t LC_HOLD  = '{en: 1'b0, flush: 1'b0};
  localparam latch_ctrl_t LC_CAP   = '{en: 1'b1, flush: 1'b0};
  localparam latch_ctrl_t LC_FLUSH = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard compare.
//   idex_memread : ID/EX instruction is a load
//   idex_rt      : ID/EX load destination register
//   ifid_rs/rt   : IF/ID source registers
//   loaduse      : IF/ID instruction consumes the in-flight load result
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             loaduse
);

  // Register 0 is hardwired zero, so a load to it never creates a hazard.
  assign loaduse = idex_memread && (idex_rt != '0) &&
                   ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencing unit for the 5-stage pipeline.
//   CLK, nRST            : clock, asynchronous active-low reset
//   ihit, dhit           : fetch / data access complete this cycle
//   dmem_req             : MEM-stage instruction accesses data memory
//   branch_taken         : MEM-stage redirect
//   halt_mem             : halt instruction in MEM
//   idex_memread/rt, ifid_rs/rt : load-use hazard inputs
//   pc_en, *_en, *_flush : PC load and per-latch capture/clear controls
//   halt                 : sticky halted indication (registered)
// Optional: define PIPE_PERF_CNT_EN to add saturating performance counters
//   stall_cycles, flush_events, loaduse_events.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             branch_taken,
  input  logic             halt_mem,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events,
  output logic [31:0]      loaduse_events
`endif
);

  pipe_state_t state, nxt;
  latch_ctrl_t ifid_c, idex_c, exmem_c, memwb_c;
  logic        pc_en_c;
  logic        loaduse;
  logic        stall;
  logic        br_win;
  logic        lu_win;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .loaduse      (loaduse)
  );

  // RUN and DSTALL share one priority chain; they differ only in the
  // stall term (DSTALL waits on dhit alone).
  always_comb begin
    nxt     = state;
    pc_en_c = 1'b0;
    ifid_c  = LC_HOLD;
    idex_c  = LC_HOLD;
    exmem_c = LC_HOLD;
    memwb_c = LC_HOLD;
    stall   = 1'b0;
    br_win  = 1'b0;
    lu_win  = 1'b0;
    case (state)
      RUN, DSTALL: begin
        stall = (state == RUN) ? (dmem_req && !dhit) : !dhit;
        if (stall) begin
          memwb_c = LC_FLUSH;
          nxt     = DSTALL;
        end else if (halt_mem) begin
          ifid_c  = LC_FLUSH;
          idex_c  = LC_FLUSH;
          exmem_c = LC_FLUSH;
          memwb_c = LC_CAP;
          nxt     = DRAIN;
        end else if (branch_taken) begin
          pc_en_c = 1'b1;
          ifid_c  = LC_FLUSH;
          idex_c  = LC_FLUSH;
          exmem_c = LC_FLUSH;
          memwb_c = LC_CAP;
          br_win  = 1'b1;
          nxt     = RUN;
        end else if (loaduse) begin
          idex_c  = LC_FLUSH;
          exmem_c = LC_CAP;
          memwb_c = LC_CAP;
          lu_win  = 1'b1;
          nxt     = RUN;
        end else if (!ihit) begin
          ifid_c  = LC_FLUSH;
          idex_c  = LC_CAP;
          exmem_c = LC_CAP;
          memwb_c = LC_CAP;
          nxt     = RUN;
        end else begin
          pc_en_c = 1'b1;
          ifid_c  = LC_CAP;
          idex_c  = LC_CAP;
          exmem_c = LC_CAP;
          memwb_c = LC_CAP;
          nxt     = RUN;
        end
      end
      DRAIN:   nxt = HALTED;
      HALTED:  nxt = HALTED;
      default: nxt = RUN;
    endcase
  end

  // Controls are forced inactive while reset is held.
  assign pc_en       = nRST && pc_en_c;
  assign ifid_en     = nRST && ifid_c.en;
  assign idex_en     = nRST && idex_c.en;
  assign exmem_en    = nRST && exmem_c.en;
  assign memwb_en    = nRST && memwb_c.en;
  assign ifid_flush  = nRST && ifid_c.flush;
  assign idex_flush  = nRST && idex_c.flush;
  assign exmem_flush = nRST && exmem_c.flush;
  assign memwb_flush = nRST && memwb_c.flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      state <= nxt;
      halt  <= (nxt == HALTED);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles   <= '0;
      flush_events   <= '0;
      loaduse_events <= '0;
    end else if (state != HALTED) begin
      if (!pc_en_c && (stall_cycles != '1))  stall_cycles   <= stall_cycles + 32'd1;
      if (br_win && (flush_events != '1))    flush_events   <= flush_events + 32'd1;
      if (lu_win && (loaduse_events != '1))  loaduse_events <= loaduse_events + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencing unit for the 5-stage pipeline.
- Generates per-latch enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the PC write enable.
- Resolves i-cache miss, d-cache wait, load-use hazard, taken branch/jump and halt drain.
- Sits beside the datapath. Its outputs drive every pipeline latch's en/flush inputs.

Parameters:
- REG_W, 5, register index width used in load-use compare.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- dmem_req  in  1  MEM-stage instruction has dREN or dWEN set
- branch_taken  in  1  MEM-stage branch/jump redirect (pcselect != sequential)
- halt_mem  in  1  halt instruction present in MEM stage
- idex_memread  in  1  ID/EX instruction is a load
- idex_rt  in  REG_W  ID/EX load destination
- ifid_rs  in  REG_W  IF/ID source register rs
- ifid_rt  in  REG_W  IF/ID source register rt
- pc_en  out  1  PC register load
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch capture enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch clear to bubble (all zero) on next edge
- halt  out  1  sticky halted indication

Behaviour:
- FSM states: RUN, DSTALL, DRAIN, HALTED. Reset (nRST low, asynchronous) forces state RUN and halt=0.
- While nRST is low, all enables are 0 and all flushes are 0.
- Flush has priority over enable inside a latch. This unit never asserts flush and en=0 on the same latch except where stated.
- dstall = dmem_req & ~dhit. loaduse = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt)).
- RUN, priority order (highest first):
  - dstall: pc_en=0; ifid/idex/exmem en=0; memwb_flush=1. Next state DSTALL.
  - halt_mem: memwb_en=1; ifid/idex/exmem flush=1; pc_en=0. Next state DRAIN.
  - branch_taken: pc_en=1; ifid/idex/exmem flush=1; memwb_en=1. Stay RUN.
  - loaduse: pc_en=0; ifid_en=0; idex_flush=1; exmem_en=memwb_en=1.
  - ~ihit: pc_en=0; ifid_flush=1; idex/exmem/memwb en=1.
  - otherwise: all en=1, all flush=0.
- DSTALL:
  - ~dhit: same outputs as the RUN dstall case.
  - dhit: outputs evaluated exactly as RUN with dstall=0 (halt/branch/loaduse/ihit rules apply). Next state per those rules, else RUN.
- DRAIN: one cycle; all en=0, all flush=0. Next state HALTED. The MEM/WB contents (halt instruction) are retained for writeback.
- HALTED: all en=0, pc_en=0, halt=1. Only reset exits.
- halt is registered: asserts on the cycle the FSM enters HALTED.
- ihit and dhit arriving together during dstall: dhit governs the exit; ihit is then evaluated in the same cycle.
- Reset mid-DSTALL: immediate return to RUN with no latch captures; the outstanding memory request is abandoned (the cache clears it on the same reset).

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, adds outputs stall_cycles[31:0], flush_events[31:0] and loaduse_events[31:0].
  - stall_cycles increments each cycle pc_en=0 while the state is not HALTED.
  - flush_events increments each cycle branch_taken causes a flush.
  - loaduse_events increments each cycle the loaduse rule wins.
  - All counters saturate at 32'hFFFF_FFFF, reset to 0, and freeze in HALTED.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_types_pkg gains pipe_state_t enum (RUN, DSTALL, DRAIN, HALTED) and a latch_ctrl_t packed struct {en, flush}.
- The outputs are grouped internally as four latch_ctrl_t.
- One sub-module, hazard_detect: combinational loaduse compare. The FSM and priority logic stay in pipeline_ctrl.

Test Plan:
- Reset then ihit=1, no hazards -> all en=1, pc_en=1, flushes 0, state RUN.
- dmem_req=1, dhit=0 for 3 cycles, then dhit=1:
  - stall cycles: pc_en=0, memwb_flush=1, state DSTALL;
  - dhit cycle: all en=1, state back to RUN.
- idex_memread=1, idex_rt=8, ifid_rs=8 -> pc_en=0, ifid_en=0, idex_flush=1. Same with idex_rt=0 -> no stall.
- branch_taken=1 together with loaduse and ihit=0 -> branch wins: pc_en=1; ifid/idex/exmem flush=1.
- halt_mem=1 in RUN -> next cycle DRAIN (all en=0), following cycle halt=1. Hold 10 cycles with ihit=1: outputs unchanged. Pulse nRST low: halt=0, state RUN.
- With PIPE_PERF_CNT_EN: 3-cycle dstall plus one loaduse -> stall_cycles=4, loaduse_events=1, flush_events=0.
